// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// frame constants, parity helper and common keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam int DATA_BITS    = 8;
  localparam int FALLS_TO_ACK = 11;

  localparam logic [7:0] CMD_LED   = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus N-sample debounce for a raw PS/2 pad input,
// producing a clean level and a one-cycle pulse on each filtered 1->0 edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic                  meta;
  logic                  sync;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_n;

  // The newest synchronized sample joins the window before the decision, so
  // the level moves after exactly FILTER_LEN equal samples.
  assign hist_n = {hist[FILTER_LEN-2:0], sync};

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= hist_n;
      fall <= 1'b0;
      if (hist_n == '1) begin
        level <= 1'b1;
      end else if (hist_n == '0) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out
// data/parity/stop on device clock falls, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ps2_tx_state_t state, state_n;
  logic [8:0]    shift, shift_n;
  logic [3:0]    falls, falls_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          clk_oe_n, data_oe_n, done_n, err_n;
  logic          clk_level, fall;
  logic          data_meta, data_s;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2clk),
    .level(clk_level),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_meta  <= 1'b1;
      data_s     <= 1'b1;
      state      <= IDLE;
      shift      <= '0;
      falls      <= '0;
      cnt        <= '0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
    end else begin
      data_meta  <= ps2data;
      data_s     <= data_meta;
      state      <= state_n;
      shift      <= shift_n;
      falls      <= falls_n;
      cnt        <= cnt_n;
      tx_ready   <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
      tx_done    <= done_n;
      tx_err     <= err_n;
      ps2clk_oe  <= clk_oe_n;
      ps2data_oe <= data_oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    falls_n   = falls;
    cnt_n     = cnt;
    clk_oe_n  = ps2clk_oe;
    data_oe_n = ps2data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid && tx_ready) begin
          state_n   = INHIBIT;
          shift_n   = {odd_parity(tx_data), tx_data};
          falls_n   = '0;
          cnt_n     = '0;
          clk_oe_n  = 1'b1;
          data_oe_n = (INHIBIT_CYCLES == 1);
        end
      end
      // The start bit is pulled low one cycle before the clock is released.
      INHIBIT: begin
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_n   = RTS;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n     = cnt + 1'b1;
          clk_oe_n  = 1'b1;
          data_oe_n = (cnt == CW'(INHIBIT_CYCLES - 2));
        end
      end
      RTS: begin
        if (fall) begin
          data_oe_n = ~shift[0];
          shift_n   = shift >> 1;
          falls_n   = 4'd1;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          data_oe_n = ~shift[0];
          shift_n   = shift >> 1;
          falls_n   = falls + 1'b1;
          if (falls == 4'(DATA_BITS)) state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          data_oe_n = 1'b0;
          falls_n   = falls + 1'b1;
          state_n   = ACK;
        end
      end
      ACK: begin
        if (fall && falls == 4'(FALLS_TO_ACK - 1)) begin
          if (!data_s) begin
            state_n = WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_level && data_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Once the clock is released the whole device exchange shares one deadline.
    if (state != IDLE && state != INHIBIT) begin
      if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state_n   = IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

endmodule
